// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (IF)
// and load/store (D). One access is in flight at a time. Data requests win by
// fixed priority unless D has been granted MAX_DSTREAK times in a row while IF
// waited. A watchdog aborts accesses that are never acknowledged.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-low reset
//   if_req_i/if_addr_i                fetch request (held until if_gnt_o)
//   if_gnt_o                          fetch accepted this cycle (combinational)
//   if_rvalid_o/if_rdata_o            fetch response pulse and instruction
//   d_req_i/d_we_i/d_addr_i/
//   d_wdata_i/d_wid_i                 load/store request (held until d_gnt_o)
//   d_gnt_o                           data accepted this cycle (combinational)
//   d_rvalid_o/d_rdata_o              completion pulse; load data (0 on stores)
//   mem_req_o/we/addr/wdata/wid       memory request, held stable until ack
//   mem_ack_i/mem_rdata_i             memory completion and read data
//   timeout_o                         pulse: access aborted by the watchdog
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned INST_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [INST_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [2:0]        d_wid_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [2:0]        mem_wid_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              timeout_o
);

  localparam int unsigned SkW = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e         state_q;
  logic           owner_d_q;  // 1: access in flight belongs to D, 0: to IF
  logic [SkW-1:0] streak_q;
  logic [WdW-1:0] wdog_q;
  logic           if_win;
  logic           idle_en;

  // Grants are only offered from IDLE and never while reset is asserted.
  always_comb begin
    idle_en  = rst_i && (state_q == StIdle);
    if_win   = if_req_i && (!d_req_i || (streak_q == SkW'(MAX_DSTREAK)));
    if_gnt_o = idle_en && if_win;
    d_gnt_o  = idle_en && d_req_i && !if_win;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      owner_d_q   <= 1'b0;
      streak_q    <= '0;
      wdog_q      <= '0;
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      d_rvalid_o  <= 1'b0;
      d_rdata_o   <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wid_o   <= 3'b000;
      timeout_o   <= 1'b0;
    end else begin
      if_rvalid_o <= 1'b0;
      d_rvalid_o  <= 1'b0;
      timeout_o   <= 1'b0;

      // Streak only grows while IF is actually being held off.
      if (!if_req_i || if_gnt_o) begin
        streak_q <= '0;
      end else if (d_gnt_o && (streak_q != SkW'(MAX_DSTREAK))) begin
        streak_q <= streak_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (if_gnt_o || d_gnt_o) begin
            state_q   <= StBusy;
            mem_req_o <= 1'b1;
            wdog_q    <= '0;
            owner_d_q <= d_gnt_o;
            if (d_gnt_o) begin
              mem_we_o    <= d_we_i;
              mem_addr_o  <= d_addr_i;
              mem_wdata_o <= d_wdata_i;
              mem_wid_o   <= d_wid_i;
            end else begin
              mem_we_o    <= 1'b0;
              mem_addr_o  <= if_addr_i;
              mem_wdata_o <= '0;
              mem_wid_o   <= 3'b010;
            end
          end
        end
        StBusy: begin
          // An ack in the final watchdog cycle still counts as completion.
          if (mem_ack_i) begin
            state_q   <= StIdle;
            mem_req_o <= 1'b0;
            if (owner_d_q) begin
              d_rvalid_o <= 1'b1;
              d_rdata_o  <= mem_we_o ? '0 : mem_rdata_i;
            end else begin
              if_rvalid_o <= 1'b1;
              if_rdata_o  <= mem_rdata_i[INST_W-1:0];
            end
          end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
            state_q   <= StIdle;
            mem_req_o <= 1'b0;
            timeout_o <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [63:0] d_addr_i;
  logic [63:0] d_wdata_i;
  logic [2:0]  d_wid_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [63:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [2:0]  mem_wid_o;
  logic        mem_ack_i;
  logic [63:0] mem_rdata_i;
  logic        timeout_o;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(
    .ADDR_W     (64),
    .DATA_W     (64),
    .INST_W     (32),
    .MAX_DSTREAK(4),
    .TIMEOUT    (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_gnt_o   (if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_wid_i    (d_wid_i),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_rdata_o  (d_rdata_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wid_o  (mem_wid_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .timeout_o  (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Advance past the next rising edge; inputs are then driven and sampled mid-cycle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; if_req_i = 1'b1; if_addr_i = '0; d_req_i = 1'b1; d_we_i = 1'b0;
    d_addr_i = '0; d_wdata_i = '0; d_wid_i = 3'b000; mem_ack_i = 1'b0; mem_rdata_i = '0;
    tick(); tick();
    #1;
    check("rst_if_gnt", if_gnt_o, 0);
    check("rst_d_gnt", d_gnt_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_if_rvalid", if_rvalid_o, 0);
    check("rst_d_rvalid", d_rvalid_o, 0);
    check("rst_d_rdata", d_rdata_o, 0);
    check("rst_timeout", timeout_o, 0);
    if_req_i = 1'b0; d_req_i = 1'b0;
    rst_i = 1'b1;
    tick();

    // 1: IF-only fetch, ack in the first BUSY cycle.
    if_req_i = 1'b1; if_addr_i = 64'h80; #1;
    check("t1_if_gnt", if_gnt_o, 1);
    check("t1_d_gnt", d_gnt_o, 0);
    tick();
    if_req_i = 1'b0;
    check("t1_mem_req", mem_req_o, 1);
    check("t1_mem_addr", mem_addr_o, 64'h80);
    check("t1_mem_we", mem_we_o, 0);
    check("t1_mem_wid", mem_wid_o, 3'b010);
    mem_ack_i = 1'b1; mem_rdata_i = 64'hFFFF_FFFF_0000_0013;
    tick();
    mem_ack_i = 1'b0;
    check("t1_if_rvalid", if_rvalid_o, 1);
    check("t1_if_rdata", if_rdata_o, 64'h13);
    check("t1_mem_req_off", mem_req_o, 0);
    check("t1_d_rvalid", d_rvalid_o, 0);
    tick();
    check("t1_if_rvalid_low", if_rvalid_o, 0);
    check("t1_if_rdata_hold", if_rdata_o, 64'h13);

    // 2: simultaneous IF and D load; D first, IF granted in the rvalid cycle.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h100;
    if_req_i = 1'b1; if_addr_i = 64'h84; #1;
    check("t2_d_gnt", d_gnt_o, 1);
    check("t2_if_gnt", if_gnt_o, 0);
    tick();
    d_req_i = 1'b0; #1;
    check("t2_mem_addr", mem_addr_o, 64'h100);
    check("t2_busy_if_gnt", if_gnt_o, 0);
    mem_ack_i = 1'b1; mem_rdata_i = 64'h1122_3344_5566_7788;
    tick();
    mem_ack_i = 1'b0;
    check("t2_d_rvalid", d_rvalid_o, 1);
    check("t2_d_rdata", d_rdata_o, 64'h1122_3344_5566_7788);
    check("t2_if_gnt_rv", if_gnt_o, 1);
    tick();
    if_req_i = 1'b0;
    check("t2_if_addr", mem_addr_o, 64'h84);
    mem_ack_i = 1'b1; mem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    mem_ack_i = 1'b0;
    check("t2_if_rvalid", if_rvalid_o, 1);
    check("t2_if_rdata", if_rdata_o, 64'hCCCC_DDDD);
    tick();

    // 3: back-to-back D with IF held: D x4, IF, then D.
    if_req_i = 1'b1; if_addr_i = 64'h88; d_req_i = 1'b1; d_we_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d_addr_i = 64'h300 + 64'(i * 8); #1;
      check($sformatf("t3_d_gnt%0d", i), d_gnt_o, (i == 4) ? 1'b0 : 1'b1);
      check($sformatf("t3_if_gnt%0d", i), if_gnt_o, (i == 4) ? 1'b1 : 1'b0);
      tick();
      check($sformatf("t3_addr%0d", i), mem_addr_o, (i == 4) ? 64'h88 : 64'h300 + 64'(i * 8));
      mem_ack_i = 1'b1; mem_rdata_i = 64'(i);
      tick();
      mem_ack_i = 1'b0;
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    tick();

    // 4: store; mem_* held across BUSY, d_rdata forced to 0.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h200; d_wdata_i = 64'hDEAD; d_wid_i = 3'b011; #1;
    check("t4_d_gnt", d_gnt_o, 1);
    tick();
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 64'h999; d_wdata_i = 64'h1234; d_wid_i = 3'b111;
    check("t4_mem_we", mem_we_o, 1);
    check("t4_mem_addr", mem_addr_o, 64'h200);
    check("t4_mem_wid", mem_wid_o, 3'b011);
    tick();
    check("t4_mem_wdata_hold", mem_wdata_o, 64'hDEAD);
    check("t4_mem_req_hold", mem_req_o, 1);
    mem_ack_i = 1'b1; mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_ack_i = 1'b0;
    check("t4_d_rvalid", d_rvalid_o, 1);
    check("t4_d_rdata", d_rdata_o, 0);
    check("t4_mem_req_off", mem_req_o, 0);
    tick();

    // 5: no ack; timeout 8 cycles after BUSY entry; late ack ignored.
    if_req_i = 1'b1; if_addr_i = 64'hC0; #1;
    check("t5_if_gnt", if_gnt_o, 1);
    tick();
    if_req_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_no_to%0d", i), timeout_o, 0);
      check($sformatf("t5_req%0d", i), mem_req_o, 1);
      tick();
    end
    check("t5_timeout", timeout_o, 1);
    check("t5_req_off", mem_req_o, 0);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    check("t5_to_pulse", timeout_o, 0);
    check("t5_late_if_rv", if_rvalid_o, 0);
    check("t5_late_d_rv", d_rvalid_o, 0);

    // 5b: ack in the last watchdog cycle completes normally.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h400; #1;
    check("t5b_d_gnt", d_gnt_o, 1);
    tick();
    d_req_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    mem_ack_i = 1'b1; mem_rdata_i = 64'h55;
    tick();
    mem_ack_i = 1'b0;
    check("t5b_d_rvalid", d_rvalid_o, 1);
    check("t5b_d_rdata", d_rdata_o, 64'h55);
    check("t5b_no_timeout", timeout_o, 0);
    tick();

    // 6: reset mid-BUSY; later ack ignored; next request works.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h500; #1;
    check("t6_d_gnt", d_gnt_o, 1);
    tick();
    rst_i = 1'b0; #1;
    check("t6_gnt_in_rst", d_gnt_o, 0);
    tick();
    check("t6_mem_req", mem_req_o, 0);
    check("t6_mem_addr", mem_addr_o, 0);
    check("t6_d_rdata", d_rdata_o, 0);
    rst_i = 1'b1; d_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 64'h77;
    tick();
    mem_ack_i = 1'b0;
    check("t6_ack_ignored", d_rvalid_o, 0);
    check("t6_idle_req", mem_req_o, 0);
    if_req_i = 1'b1; if_addr_i = 64'hE0; #1;
    check("t6_if_gnt", if_gnt_o, 1);
    tick();
    if_req_i = 1'b0;
    check("t6_if_addr", mem_addr_o, 64'hE0);
    mem_ack_i = 1'b1; mem_rdata_i = 64'h0000_0000_CAFE_F00D;
    tick();
    mem_ack_i = 1'b0;
    check("t6_if_rvalid", if_rvalid_o, 1);
    check("t6_if_rdata", if_rdata_o, 64'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
